instruction_loader: RTL and testbench
=====================================

# instruction_loader

Program loader for the byte-wide instruction memory read by the fetch stage. It accepts 32-bit instruction words over a valid/ready stream and writes each word as four consecutive bytes, little-endian: byte at address a holds word[7:0], byte at a+3 holds word[31:24]. The fetch stage rebuilds the word as {m[a+3],m[a+2],m[a+1],m[a]}. The loader sits between the testbench or boot source and the i_mem array, and owns its single byte write port.

## Interface
- ADDR_WIDTH, 8, byte address width; memory depth 2^ADDR_WIDTH bytes (256 by default).
- START_ADDR, 0, first byte address written; must be a multiple of 4.
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  in_word/in_last are valid.
- in_ready  output  1  loader can accept a word; combinational, high only in IDLE with reset high.
- in_word  input  32  instruction word.
- in_last  input  1  marks the final word of the program.
- restart  input  1  in DONE only: clear counters and return to IDLE.
- mem_we  output  1  byte write enable (registered).
- mem_addr  output  ADDR_WIDTH  byte write address (registered).
- mem_wdata  output  8  byte write data (registered).
- word_count  output  ADDR_WIDTH-1  number of complete words written.
- done  output  1  load finished (registered).
- overflow  output  1  memory filled before in_last was seen (registered).

## Operation
- States: IDLE, WRITE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at a clock edge: latch in_word and in_last, set byte index idx=0, go to WRITE.
- WRITE: one byte per cycle with mem_we=1, mem_addr=base+idx and mem_wdata=word[8*idx+7:8*idx], for idx=0,1,2,3.
  - After the idx=3 cycle: word_count+=1 and base+=4.
  - Next state:
    - DONE if the latched last=1, or if word_count has reached 2^(ADDR_WIDTH-2) (memory full).
    - IDLE otherwise.
  - If memory is full and last=0, set overflow=1.
- DONE:
  - done=1, in_ready=0, mem_we=0. Incoming words are ignored and not acknowledged.
  - restart=1 returns to IDLE with base=START_ADDR, word_count=0, done=0, overflow=0.
  - restart in IDLE or WRITE is ignored.
- Address arithmetic is modulo 2^ADDR_WIDTH; base wraps to 0 past the top of memory. The full check relies on word_count, not on the address wrap.
- in_valid held without in_ready is simply held; no data is lost or duplicated.
- reset low (at any time, including mid-WRITE):
  - state=IDLE, mem_we=0, mem_addr=START_ADDR, mem_wdata=0, word_count=0, done=0, overflow=0, base=START_ADDR.
  - A partially written word stays in memory; no further bytes are written.

## Timing
- Handshake sampled at edge E0. mem_we is high in the four cycles after E0, and memory captures bytes at edges E1..E4.
- After E4:
  - word_count updated; state is IDLE or DONE.
  - in_ready high in the cycle after E4 if IDLE.
  - done high in the cycle after E4 if DONE.
- Throughput: one word per 5 cycles. Minimum handshake-to-handshake spacing is 5 edges.
- mem_we deasserts in the cycle after E4; no idle write cycles occur inside a word.
- in_ready is 0 for the whole of WRITE and DONE, and while reset is low.
- restart sampled at edge R: in_ready=1 in the cycle after R.

## Test plan
- Reset, then one word 0x8C220004 with in_last=1.
  - Writes: addr 0..3 = 0x04, 0x00, 0x22, 0x8C on consecutive cycles.
  - Then word_count=1 and done=1; in_ready=0 thereafter.
- Three back-to-back words 0x11111111, 0x22223333, 0xAABBCCDD (last on the third).
  - Bytes land at 0..11.
  - in_ready low for exactly 4 cycles after each accept.
  - word_count=3, overflow=0.
- in_valid toggling randomly with the same words:
  - Byte sequence in memory is identical to the back-to-back case.
  - No duplicate or dropped words.
- ADDR_WIDTH=4, START_ADDR=8, 5 words, no in_last.
  - After the 4th word: done=1, overflow=1, word_count=4.
  - Writes seen: 8..15 then 0..7 (wrap).
  - The 5th word is never acknowledged.
- reset driven low after the 2nd byte of word 2.
  - Bytes 4 and 5 are written, bytes 6 and 7 are not.
  - Next cycle: all outputs at reset values and word_count=0.
  - Reloading rewrites from START_ADDR.
- In DONE, pulse restart:
  - in_ready=1 next cycle.
  - A new word 0xDEADBEEF writes EF, BE, AD, DE to addresses 0..3.

Source files
------------

// File: rtl/instruction_loader.sv
// Program loader: takes 32-bit instruction words over valid/ready and writes each
// one into byte-wide instruction memory as four little-endian bytes, one per cycle.
module instruction_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int START_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_word,
  input  logic                  in_last,
  input  logic                  restart,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic [ADDR_WIDTH-2:0] word_count,
  output logic                  done,
  output logic                  overflow
);

  localparam int CW = ADDR_WIDTH - 1;
  localparam logic [ADDR_WIDTH-1:0] START = ADDR_WIDTH'(START_ADDR);
  // word_count value just before the word that fills the last free slot
  localparam logic [CW-1:0] LAST_SLOT = CW'((1 << (ADDR_WIDTH - 2)) - 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base;
  logic [1:0]            idx;
  logic [1:0]            idx_nxt;
  logic [31:0]           word_q;
  logic                  last_q;
  logic                  accept;
  logic                  full_next;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    return w[8*i +: 8];
  endfunction

  assign in_ready  = reset && (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign idx_nxt   = idx + 2'd1;
  assign full_next = (word_count == LAST_SLOT);

  always_ff @(posedge clk) begin
    if (accept) begin
      word_q <= in_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      base       <= START;
      idx        <= 2'd0;
      last_q     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= START;
      mem_wdata  <= 8'd0;
      word_count <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= WRITE;
            idx       <= 2'd0;
            last_q    <= in_last;
            mem_we    <= 1'b1;
            mem_addr  <= base;
            mem_wdata <= in_word[7:0];
          end
        end
        WRITE: begin
          if (idx == 2'd3) begin
            mem_we     <= 1'b0;
            base       <= base + ADDR_WIDTH'(4);
            word_count <= word_count + CW'(1);
            if (last_q || full_next) begin
              state    <= DONE;
              done     <= 1'b1;
              overflow <= full_next && !last_q;
            end else begin
              state <= IDLE;
            end
          end else begin
            idx       <= idx_nxt;
            mem_addr  <= base + ADDR_WIDTH'(idx_nxt);
            mem_wdata <= byte_sel(word_q, idx_nxt);
          end
        end
        DONE: begin
          if (restart) begin
            state      <= IDLE;
            base       <= START;
            word_count <= '0;
            done       <= 1'b0;
            overflow   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: a default 256-byte instance and a
// 16-byte instance starting at address 8 for the memory-full case.
module tb_instruction_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        a_valid = 1'b0, a_last = 1'b0, a_restart = 1'b0;
  logic [31:0] a_word = '0;
  logic        a_in_ready, a_mem_we, a_done, a_overflow;
  logic [7:0]  a_mem_addr, a_mem_wdata;
  logic [6:0]  a_wc;

  // small instance
  logic        b_valid = 1'b0, b_last = 1'b0, b_restart = 1'b0;
  logic [31:0] b_word = '0;
  logic        b_in_ready, b_mem_we, b_done, b_overflow;
  logic [3:0]  b_mem_addr;
  logic [7:0]  b_mem_wdata;
  logic [2:0]  b_wc;

  instruction_loader dut_a (
    .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a_in_ready),
    .in_word(a_word), .in_last(a_last), .restart(a_restart), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .word_count(a_wc),
    .done(a_done), .overflow(a_overflow)
  );

  instruction_loader #(.ADDR_WIDTH(4), .START_ADDR(8)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_in_ready),
    .in_word(b_word), .in_last(b_last), .restart(b_restart), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .word_count(b_wc),
    .done(b_done), .overflow(b_overflow)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] a_q[$];
  logic [11:0] b_q[$];
  logic [15:0] a_exp;
  logic [11:0] b_exp;
  int a_base = 0, a_cnt = 0;
  int b_base = 8, b_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // write monitors: every byte write must match the head of the expected queue
  always @(negedge clk) begin
    if (a_mem_we === 1'b1) begin
      checks++;
      if (a_q.size() == 0) begin
        errors++;
        $display("FAIL a_write unexpected addr=%0h data=%0h", a_mem_addr, a_mem_wdata);
      end else begin
        a_exp = a_q.pop_front();
        if ({a_mem_addr, a_mem_wdata} !== a_exp) begin
          errors++;
          $display("FAIL a_write got addr=%0h data=%0h want addr=%0h data=%0h",
                   a_mem_addr, a_mem_wdata, a_exp[15:8], a_exp[7:0]);
        end
      end
    end
    if (b_mem_we === 1'b1) begin
      checks++;
      if (b_q.size() == 0) begin
        errors++;
        $display("FAIL b_write unexpected addr=%0h data=%0h", b_mem_addr, b_mem_wdata);
      end else begin
        b_exp = b_q.pop_front();
        if ({b_mem_addr, b_mem_wdata} !== b_exp) begin
          errors++;
          $display("FAIL b_write got addr=%0h data=%0h want addr=%0h data=%0h",
                   b_mem_addr, b_mem_wdata, b_exp[11:8], b_exp[7:0]);
        end
      end
    end
  end

  // Called just after a negedge. With check_gap the task returns just after the
  // negedge following the fourth write edge; otherwise right after the handshake.
  task automatic send_a(input logic [31:0] w, input logic last, input bit check_gap,
                        input int gap);
    int n;
    for (int k = 0; k < 4; k++) a_q.push_back({8'((a_base + k) & 255), w[8*k +: 8]});
    a_base = (a_base + 4) & 255;
    a_cnt++;
    a_valid = 1'b0;
    repeat (gap) @(negedge clk);
    a_valid = 1'b1; a_word = w; a_last = last;
    n = 0;
    while (!a_in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      chk("a_accept_timeout", 32'd1, 32'd0);
      a_valid = 1'b0;
      return;
    end
    @(negedge clk);
    a_valid = 1'b0;
    if (check_gap) begin
      for (int c = 0; c < 4; c++) begin
        chk("a_ready_low_in_write", a_in_ready, 0);
        @(negedge clk);
      end
      chk("a_ready_after_word", a_in_ready, !last);
      chk("a_done_after_word", a_done, last);
      chk("a_word_count", a_wc, a_cnt);
      chk("a_we_off_after_word", a_mem_we, 0);
    end
  endtask

  task automatic restart_a();
    @(negedge clk);
    a_restart = 1'b1;
    @(negedge clk);
    a_restart = 1'b0;
    chk("a_ready_after_restart", a_in_ready, 1);
    chk("a_done_after_restart", a_done, 0);
    chk("a_wc_after_restart", a_wc, 0);
    chk("a_ovf_after_restart", a_overflow, 0);
    a_base = 0;
    a_cnt  = 0;
  endtask

  task automatic send_b(input logic [31:0] w, input logic exp_done, input logic exp_ovf);
    int n;
    for (int k = 0; k < 4; k++) b_q.push_back({4'((b_base + k) & 15), w[8*k +: 8]});
    b_base = (b_base + 4) & 15;
    b_cnt++;
    b_valid = 1'b1; b_word = w; b_last = 1'b0;
    n = 0;
    while (!b_in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      chk("b_accept_timeout", 32'd1, 32'd0);
      b_valid = 1'b0;
      return;
    end
    @(negedge clk);
    b_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("b_done", b_done, exp_done);
    chk("b_overflow", b_overflow, exp_ovf);
    chk("b_word_count", b_wc, b_cnt);
    chk("b_ready", b_in_ready, !exp_done);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    chk("rst_ready", a_in_ready, 0);
    chk("rst_we", a_mem_we, 0);
    chk("rst_addr", a_mem_addr, 0);
    chk("rst_wdata", a_mem_wdata, 0);
    chk("rst_wc", a_wc, 0);
    chk("rst_done", a_done, 0);
    chk("rst_ovf", a_overflow, 0);
    chk("rst_b_addr", b_mem_addr, 8);
    reset = 1'b1;
    #1;
    chk("ready_after_reset", a_in_ready, 1);
    @(negedge clk);

    // single word with last: 04 00 22 8C at 0..3
    send_a(32'h8C220004, 1'b1, 1'b1, 0);
    a_valid = 1'b1; a_word = 32'h12345678; a_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("a_ready_in_done", a_in_ready, 0);
    end
    a_valid = 1'b0;
    chk("a_wc_in_done", a_wc, 1);
    chk("a_done_held", a_done, 1);

    // restart then DEADBEEF: EF BE AD DE at 0..3
    restart_a();
    send_a(32'hDEADBEEF, 1'b1, 1'b1, 0);

    // three back-to-back words, bytes at 0..11
    restart_a();
    send_a(32'h11111111, 1'b0, 1'b1, 0);
    send_a(32'h22223333, 1'b0, 1'b1, 0);
    send_a(32'hAABBCCDD, 1'b1, 1'b1, 0);
    chk("a_b2b_ovf", a_overflow, 0);

    // same words with irregular valid, sometimes held during WRITE
    restart_a();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: send_a(32'h11111111, 1'b0, 1'b0, $urandom_range(0, 3));
        1: send_a(32'h22223333, 1'b0, 1'b0, $urandom_range(0, 3));
        default: send_a(32'hAABBCCDD, 1'b1, 1'b0, $urandom_range(0, 3));
      endcase
    end
    repeat (10) @(negedge clk);
    chk("a_rand_done", a_done, 1);
    chk("a_rand_wc", a_wc, 3);
    chk("a_rand_ovf", a_overflow, 0);

    // reset after the second byte of word 2: bytes 4,5 written, 6,7 not
    restart_a();
    send_a(32'h01020304, 1'b0, 1'b1, 0);
    a_q.push_back({8'd4, 8'h88});
    a_q.push_back({8'd5, 8'h77});
    a_valid = 1'b1; a_word = 32'h55667788; a_last = 1'b0;
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_we", a_mem_we, 0);
    chk("midrst_addr", a_mem_addr, 0);
    chk("midrst_wdata", a_mem_wdata, 0);
    chk("midrst_wc", a_wc, 0);
    chk("midrst_done", a_done, 0);
    chk("midrst_ovf", a_overflow, 0);
    chk("midrst_ready", a_in_ready, 0);
    reset = 1'b1;
    a_base = 0;
    a_cnt  = 0;
    @(negedge clk);
    chk("midrst_ready_after", a_in_ready, 1);
    send_a(32'hCAFEF00D, 1'b1, 1'b1, 0);

    // 16-byte memory from address 8: wraps, fills after 4 words
    send_b(32'h03020100, 1'b0, 1'b0);
    send_b(32'h07060504, 1'b0, 1'b0);
    send_b(32'h0B0A0908, 1'b0, 1'b0);
    send_b(32'h0F0E0D0C, 1'b1, 1'b1);
    b_valid = 1'b1; b_word = 32'h13121110; b_last = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("b_fifth_not_acked", b_in_ready, 0);
    end
    b_valid = 1'b0;
    chk("b_final_wc", b_wc, 4);

    repeat (10) @(negedge clk);
    chk("a_queue_drained", a_q.size(), 0);
    chk("b_queue_drained", b_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
